// File: rtl/rst_seq_ctrl_pkg.sv
// Shared constants for the reset release sequencer: FSM state encodings,
// the state_dbg width and a counter-width helper.
package rst_seq_ctrl_pkg;

  localparam int STATE_W = 2;

  // State encodings are fixed because state_dbg is decoded by software.
  localparam logic [STATE_W-1:0] ST_HOLD      = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [STATE_W-1:0] ST_STAGE     = 2'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

  // Width of a counter that runs 0..terminal-1, never narrower than 1 bit.
  function automatic int cnt_w(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Bundle of the sequencer's lock/request inputs and reset/status outputs.
// The sequencer sits on the slave side; whoever drives lock and requests
// and consumes the resets uses the master side.
interface rst_seq_ctrl_if
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STAGES = 4
);

  logic                locked;
  logic                sw_rst_req;
  logic [N_STAGES-1:0] rst_out;
  logic                seq_done;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    output locked,
    output sw_rst_req,
    input  rst_out,
    input  seq_done,
    input  state_dbg
  );

  modport slave (
    input  locked,
    input  sw_rst_req,
    output rst_out,
    output seq_done,
    output state_dbg
  );

endinterface

// File: rtl/rst_seq_ctrl_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous clear. The chain
// clears to 0 so a lock indication is never seen as high during reset.
module rst_seq_ctrl_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_ff;

  // Shift the asynchronous input through the metastability chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds all downstream resets until the clock
// source lock has been stable for LOCK_FILT sampled cycles, then releases
// rst_out[0], rst_out[1], ... one every STAGE_DLY cycles. Lock loss or a
// software request in STAGE/RUN re-asserts everything and restarts.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILT   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           async_rst,
  rst_seq_ctrl_if.slave  bus
);

  localparam int LOCK_W = cnt_w(LOCK_FILT);
  localparam int DLY_W  = cnt_w(STAGE_DLY);
  localparam int IDX_W  = cnt_w(N_STAGES);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_STAGES - 1);

  logic                locked_sync;
  logic                abort;

  logic [STATE_W-1:0]  state_q,    state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DLY_W-1:0]    dly_cnt_q,  dly_cnt_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [N_STAGES-1:0] rst_out_q,  rst_out_d;
  logic                seq_done_q, seq_done_d;

  rst_seq_ctrl_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (async_rst),
    .d   (bus.locked),
    .q   (locked_sync)
  );

  // Lock loss outranks the software request, but both produce the same
  // restart, so a single abort term covers them.
  assign abort = !locked_sync || bus.sw_rst_req;

  // Next-state logic: lock filter, release timer and abort handling.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;

    if ((state_q == ST_STAGE || state_q == ST_RUN) && abort) begin
      // Abort beats any release that happens to fall on this edge.
      state_d    = ST_WAIT_LOCK;
      lock_cnt_d = '0;
      dly_cnt_d  = '0;
      idx_d      = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_WAIT_LOCK;
        end

        ST_WAIT_LOCK: begin
          // Software requests are meaningless here: resets are still held.
          if (locked_sync) begin
            if (lock_cnt_q == LOCK_LAST) begin
              state_d    = ST_STAGE;
              lock_cnt_d = '0;
              dly_cnt_d  = '0;
              idx_d      = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end else begin
            lock_cnt_d = '0;
          end
        end

        ST_STAGE: begin
          if (dly_cnt_q == DLY_LAST) begin
            dly_cnt_d = '0;
            idx_d     = idx_q + 1'b1;
            for (int k = 0; k < N_STAGES; k++) begin
              if (IDX_W'(k) == idx_q) begin
                rst_out_d[k] = 1'b0;
              end
            end
            if (idx_q == IDX_LAST) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // State, counters and outputs; async reset holds every domain in reset.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q    <= ST_HOLD;
      lock_cnt_q <= '0;
      dly_cnt_q  <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.state_dbg = state_q;

endmodule
